// File: rtl/usb_rx_bit_recovery_pkg.sv
// Shared types and constants for the USB full-speed receive front end.
// Line states are encoded as {dp, dm}.
package usb_rx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      EOP
   } rx_state_t;

   typedef logic [1:0] line_t;

   localparam line_t LINE_J   = 2'b10;
   localparam line_t LINE_K   = 2'b01;
   localparam line_t LINE_SE0 = 2'b00;

   localparam int unsigned DEF_CLKS_PER_BIT = 8;
   localparam int unsigned DEF_SAMPLE_PHASE = 3;
   localparam int unsigned DEF_STUFF_LEN    = 6;
   localparam int unsigned DEF_NUM_BITS     = 8;

   // NRZI: no transition decodes as 1, a transition decodes as 0.
   function automatic logic nrzi_bit(input line_t cur, input line_t prev);
      return cur == prev;
   endfunction

endpackage

// File: rtl/usb_rx_bit_recovery_if.sv
// Line inputs and shift-register/controller outputs of the bit recovery block.
// The master modport is the recovery block itself; slave is its environment.
interface usb_rx_bit_recovery_if;

   logic d_plus_sync;
   logic d_minus_sync;
   logic serial_in;
   logic shift_enable;
   logic byte_valid;
   logic eop;
   logic stuff_error;
   logic rx_active;

   modport master (
      input  d_plus_sync,
      input  d_minus_sync,
      output serial_in,
      output shift_enable,
      output byte_valid,
      output eop,
      output stuff_error,
      output rx_active
   );

   modport slave (
      output d_plus_sync,
      output d_minus_sync,
      input  serial_in,
      input  shift_enable,
      input  byte_valid,
      input  eop,
      input  stuff_error,
      input  rx_active
   );

endinterface

// File: rtl/usb_rx_bit_recovery_bit_timer.sv
// Free-running bit-time counter that resyncs to zero on every D+ edge and
// emits the mid-bit sample strobe while the receiver is enabled.
module usb_bit_timer
   import usb_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int unsigned SAMPLE_PHASE = DEF_SAMPLE_PHASE
) (
   input  logic clk,
   input  logic rst,
   input  logic resync,
   input  logic enable,
   output logic sample
);

   localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [TimerW-1:0] timer_q;
   logic [TimerW-1:0] timer_d;

   always_comb begin
      timer_d = timer_q + 1'b1;
      if (timer_q == TimerW'(CLKS_PER_BIT - 1)) begin
         timer_d = '0;
      end
      // Resync wins over wrap so the sample point tracks the last observed edge.
      if (resync) begin
         timer_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign sample = enable && (timer_q == TimerW'(SAMPLE_PHASE));

endmodule

// File: rtl/usb_rx_bit_recovery.sv
// USB full-speed receive front end: bit timing recovery, NRZI decode and
// bit unstuffing feeding an LSB-first serial-to-parallel shift register.
module usb_rx_bit_recovery
   import usb_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int unsigned SAMPLE_PHASE = DEF_SAMPLE_PHASE,
   parameter int unsigned STUFF_LEN    = DEF_STUFF_LEN,
   parameter int unsigned NUM_BITS     = DEF_NUM_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   usb_rx_bit_recovery_if.master bus
);

   localparam int unsigned OnesW = $clog2(STUFF_LEN + 1);
   localparam int unsigned BitW  = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

   // Input pipeline flops simply track the (already synchronized) line, even in
   // reset, so leaving reset never fabricates an edge.
   logic dp_q;
   logic dm_q;

   always_ff @(posedge clk) begin
      dp_q <= bus.d_plus_sync;
      dm_q <= bus.d_minus_sync;
   end

   line_t line;
   logic  edge_det;
   logic  sample;
   logic  timer_en;
   logic  dec_bit;

   rx_state_t         state_q;
   line_t             prev_line_q;
   logic [OnesW-1:0]  ones_q;
   logic [BitW-1:0]   bitcnt_q;
   logic              byte_arm_q;
   logic              serial_in_q;
   logic              shift_enable_q;
   logic              byte_valid_q;
   logic              eop_q;
   logic              stuff_error_q;
   logic              rx_active_q;

   assign line     = {dp_q, dm_q};
   assign edge_det = bus.d_plus_sync ^ dp_q;
   assign timer_en = (state_q == ACTIVE) || (state_q == EOP);
   assign dec_bit  = nrzi_bit(line, prev_line_q);

   usb_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .SAMPLE_PHASE (SAMPLE_PHASE)
   ) u_bit_timer (
      .clk    (clk),
      .rst    (rst),
      .resync (edge_det),
      .enable (timer_en),
      .sample (sample)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         prev_line_q    <= LINE_J;
         ones_q         <= '0;
         bitcnt_q       <= '0;
         byte_arm_q     <= 1'b0;
         serial_in_q    <= 1'b1;
         shift_enable_q <= 1'b0;
         byte_valid_q   <= 1'b0;
         eop_q          <= 1'b0;
         stuff_error_q  <= 1'b0;
         rx_active_q    <= 1'b0;
      end else begin
         shift_enable_q <= 1'b0;
         eop_q          <= 1'b0;
         stuff_error_q  <= 1'b0;
         // byte_valid trails the final shift_enable so the register is settled.
         byte_valid_q   <= byte_arm_q;
         byte_arm_q     <= 1'b0;

         unique case (state_q)
            IDLE: begin
               if (edge_det && dp_q && !bus.d_plus_sync) begin
                  state_q     <= ACTIVE;
                  rx_active_q <= 1'b1;
                  prev_line_q <= LINE_J;
                  ones_q      <= '0;
                  bitcnt_q    <= '0;
               end
            end

            ACTIVE: begin
               if (sample) begin
                  if (line == LINE_SE0) begin
                     state_q  <= EOP;
                     bitcnt_q <= '0;
                  end else begin
                     prev_line_q <= line;
                     if (ones_q == OnesW'(STUFF_LEN)) begin
                        ones_q <= '0;
                        if (dec_bit) begin
                           stuff_error_q <= 1'b1;
                           rx_active_q   <= 1'b0;
                           state_q       <= IDLE;
                        end
                     end else begin
                        serial_in_q    <= dec_bit;
                        shift_enable_q <= 1'b1;
                        ones_q         <= dec_bit ? ones_q + 1'b1 : '0;
                        if (bitcnt_q == BitW'(NUM_BITS - 1)) begin
                           bitcnt_q   <= '0;
                           byte_arm_q <= 1'b1;
                        end else begin
                           bitcnt_q <= bitcnt_q + 1'b1;
                        end
                     end
                  end
               end
            end

            EOP: begin
               if (sample) begin
                  if (line == LINE_J) begin
                     eop_q       <= 1'b1;
                     rx_active_q <= 1'b0;
                     prev_line_q <= LINE_J;
                     state_q     <= IDLE;
                  end else if (line != LINE_SE0) begin
                     stuff_error_q <= 1'b1;
                     rx_active_q   <= 1'b0;
                     state_q       <= IDLE;
                  end
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.serial_in    = serial_in_q;
   assign bus.shift_enable = shift_enable_q;
   assign bus.byte_valid   = byte_valid_q;
   assign bus.eop          = eop_q;
   assign bus.stuff_error  = stuff_error_q;
   assign bus.rx_active    = rx_active_q;

endmodule

// File: tb/tb_usb_rx_bit_recovery.sv
// Self-checking bench: drives NRZI/bit-stuffed packets on D+/D- and checks the
// decoded bytes, pulses and sample timing against a packet-level model.
module tb_usb_rx_bit_recovery;
   import usb_rx_pkg::*;

   localparam int CLKS = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   usb_rx_bit_recovery_if rxi ();

   usb_rx_bit_recovery #(
      .CLKS_PER_BIT (8),
      .SAMPLE_PHASE (3),
      .STUFF_LEN    (6),
      .NUM_BITS     (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (rxi.master)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream LSB-first shift register (resets to all ones).
   logic [7:0] shreg;
   always @(posedge clk) begin
      if (rst) shreg <= 8'hFF;
      else if (rxi.shift_enable) shreg <= {rxi.serial_in, shreg[7:1]};
   end

   // Event recorder, sampled away from the active edge.
   int         se_cyc_q[$];
   logic [7:0] bytes_q[$];
   int         eop_cnt = 0;
   int         err_cnt = 0;
   int         bad_cnt = 0;
   always @(negedge clk) begin
      if (rxi.shift_enable) se_cyc_q.push_back(cyc);
      if (rxi.byte_valid) begin
         bytes_q.push_back(shreg);
         if (!rxi.rx_active) bad_cnt++;
      end
      if (rxi.shift_enable && rxi.byte_valid) bad_cnt++;
      if (rxi.eop) begin
         eop_cnt++;
         if (rxi.rx_active) bad_cnt++;
      end
      if (rxi.stuff_error) begin
         err_cnt++;
         if (rxi.rx_active) bad_cnt++;
      end
   end

   int         n_tests = 0;
   int         n_fail  = 0;
   int         t_base;
   line_t      lvl;
   int         edge_q[$];
   logic [7:0] data_q[$];
   bit         txq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one symbol at its nominal boundary, optionally jittered by +/-1 clk.
   task automatic tx_sym(input line_t ln, input bit jit);
      int tgt;
      tgt = t_base + (jit ? int'($urandom_range(2)) - 1 : 0);
      while (cyc < tgt) @(negedge clk);
      if (rxi.d_plus_sync !== ln[1]) edge_q.push_back(cyc);
      rxi.d_plus_sync  = ln[1];
      rxi.d_minus_sync = ln[0];
      t_base += CLKS;
   endtask

   task automatic start_frame();
      @(negedge clk);
      t_base = cyc + 1;
      lvl    = LINE_J;
   endtask

   // SYNC (seven 0s then a 1) followed by data LSB-first, stuffing after six 1s.
   task automatic build_stream(input bit do_stuff);
      int ones;
      txq  = {};
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         bit b;
         b = (i == 7);
         txq.push_back(b);
         ones = b ? ones + 1 : 0;
      end
      foreach (data_q[k]) begin
         for (int i = 0; i < 8; i++) begin
            bit b;
            b = data_q[k][i];
            txq.push_back(b);
            ones = b ? ones + 1 : 0;
            if (do_stuff && ones == 6) begin
               txq.push_back(1'b0);
               ones = 0;
            end
         end
      end
   endtask

   task automatic tx_bits(input bit jit, input int nmax);
      for (int i = 0; i < txq.size() && (nmax < 0 || i < nmax); i++) begin
         if (!txq[i]) lvl = (lvl == LINE_J) ? LINE_K : LINE_J;
         tx_sym(lvl, jit);
      end
   endtask

   task automatic tx_idle(input int n);
      for (int i = 0; i < n; i++) tx_sym(LINE_J, 1'b0);
      lvl = LINE_J;
      while (cyc < t_base + CLKS) @(negedge clk);
   endtask

   // Full packet with EOP; compares against bytes = {0x80, data...}.
   task automatic run_packet(input string tag, input bit jit);
      int b0, e0, r0, s0, x0, bad0, viol, n_exp;
      b0 = bytes_q.size(); e0 = eop_cnt; r0 = err_cnt; s0 = se_cyc_q.size();
      x0 = edge_q.size(); bad0 = bad_cnt;
      build_stream(1'b1);
      start_frame();
      tx_bits(jit, -1);
      tx_sym(LINE_SE0, jit);
      tx_sym(LINE_SE0, jit);
      tx_sym(LINE_J, jit);
      tx_idle(2);
      n_exp = 1 + data_q.size();
      check({tag, "_nbytes"}, bytes_q.size() - b0, n_exp);
      for (int i = 0; i < n_exp && b0 + i < bytes_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), bytes_q[b0 + i],
               (i == 0) ? 8'h80 : data_q[i - 1]);
      check({tag, "_nshift"}, se_cyc_q.size() - s0, 8 * n_exp);
      check({tag, "_eop"}, eop_cnt - e0, 1);
      check({tag, "_stuff_err"}, err_cnt - r0, 0);
      check({tag, "_protocol"}, bad_cnt - bad0, 0);
      // Each shift must follow the most recent edge by 5 clks (+ whole bit times).
      viol = 0;
      for (int i = s0; i < se_cyc_q.size(); i++) begin
         int last;
         last = -1000;
         for (int j = x0; j < edge_q.size(); j++)
            if (edge_q[j] + 5 <= se_cyc_q[i]) last = edge_q[j];
         if ((se_cyc_q[i] - last - 5) % CLKS != 0) viol++;
      end
      check({tag, "_timing"}, viol, 0);
   endtask

   int b0, e0, r0, s0, bad0;

   initial begin
      rxi.d_plus_sync  = 1'b1;
      rxi.d_minus_sync = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_serial_in", rxi.serial_in, 1);
      check("rst_shift_enable", rxi.shift_enable, 0);
      check("rst_byte_valid", rxi.byte_valid, 0);
      check("rst_eop", rxi.eop, 0);
      check("rst_stuff_error", rxi.stuff_error, 0);
      check("rst_rx_active", rxi.rx_active, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      data_q = {};
      run_packet("sync_only", 1'b0);
      data_q = {8'hFF};
      run_packet("data_ff", 1'b0);
      data_q = {8'hA5};
      run_packet("data_a5", 1'b0);
      data_q = {};
      run_packet("sync_jitter", 1'b1);

      // Seven consecutive decoded 1s with no stuffed bit.
      b0 = bytes_q.size(); e0 = eop_cnt; r0 = err_cnt; s0 = se_cyc_q.size(); bad0 = bad_cnt;
      data_q = {8'h3F};
      build_stream(1'b0);
      start_frame();
      tx_bits(1'b0, 14);
      tx_idle(3);
      check("stuff7_err", err_cnt - r0, 1);
      check("stuff7_eop", eop_cnt - e0, 0);
      check("stuff7_nbytes", bytes_q.size() - b0, 1);
      check("stuff7_nshift", se_cyc_q.size() - s0, 13);
      check("stuff7_protocol", bad_cnt - bad0, 0);

      // Reset in the middle of the first data byte.
      data_q = {8'h3C};
      build_stream(1'b1);
      start_frame();
      tx_bits(1'b0, 11);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_serial_in", rxi.serial_in, 1);
      check("mid_rst_shift_enable", rxi.shift_enable, 0);
      check("mid_rst_byte_valid", rxi.byte_valid, 0);
      check("mid_rst_eop", rxi.eop, 0);
      check("mid_rst_stuff_error", rxi.stuff_error, 0);
      check("mid_rst_rx_active", rxi.rx_active, 0);
      b0 = bytes_q.size(); e0 = eop_cnt; r0 = err_cnt; s0 = se_cyc_q.size();
      start_frame();
      tx_idle(4);
      check("post_rst_quiet", (bytes_q.size() - b0) + (eop_cnt - e0) + (err_cnt - r0)
            + (se_cyc_q.size() - s0), 0);
      data_q = {8'h5A};
      run_packet("post_rst", 1'b0);

      // Randomized payloads and jitter.
      for (int p = 0; p < 6; p++) begin
         int n;
         n = int'($urandom_range(3, 1));
         data_q = {};
         for (int k = 0; k < n; k++) data_q.push_back(8'($urandom));
         if (p == 0) data_q = {8'hFF, 8'hFE, 8'h7F};
         run_packet($sformatf("rand%0d", p), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
